systolic_skew_feeder: RTL and testbench

- Upstream operand stage for the DIMxDIM systolic MAC array.
- Buffers DIM operand vectors ("waves") loaded over a write port, then streams them out with diagonal skew: lane i is delayed i cycles, and empty slots are zero-padded.
- Its output vector drives the array's A (or B) edge inputs and its en input directly; two instances feed A and B.

---
 rtl/systolic_skew_feeder_if.sv | 26 ++
 rtl/systolic_skew_feeder.sv | 123 ++++++++++++
 tb/tb_systolic_skew_feeder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_skew_feeder_if.sv
// Operand-feeder bus: wave write port, stream control, and the skewed
// operand vector with its array-enable and status flags.
interface systolic_skew_feeder_if #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
);
  logic                         wr_en;
  logic [$clog2(DIM)-1:0]       wr_idx;
  logic [DIM-1:0][BITS_AB-1:0]  wr_data;
  logic                         start;
  logic                         stall;
  logic [DIM-1:0][BITS_AB-1:0]  A_out;
  logic                         en_out;
  logic                         busy;
  logic                         done;

  modport master (
    output wr_en, wr_idx, wr_data, start, stall,
    input  A_out, en_out, busy, done
  );

  modport slave (
    input  wr_en, wr_idx, wr_data, start, stall,
    output A_out, en_out, busy, done
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skewed operand feeder for a DIMxDIM systolic array. Holds DIM waves and
// streams them diagonally: lane i lags lane 0 by i steps, empty slots are 0.
// All outputs come straight from registers.
module systolic_skew_feeder #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input logic                   clk,
  input logic                   rst,
  systolic_skew_feeder_if.slave bus
);
  localparam int KW = $clog2(2 * DIM);
  localparam logic [KW-1:0] ALL_ISSUED = KW'(2 * DIM - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                      state, state_next;
  logic [KW-1:0]               k, k_next;
  logic [DIM-1:0][BITS_AB-1:0] wave_mem [DIM];
  logic [DIM-1:0][BITS_AB-1:0] a_reg, a_next, step_vec;
  logic                        en_reg, en_next;
  logic                        busy_reg, busy_next;
  logic                        done_reg, done_next;
  logic                        wr_accept;

  // Writes land only while idle, so a running stream sees a frozen buffer.
  assign wr_accept = bus.wr_en && (state == IDLE);

  // Diagonal slice for step k; a same-cycle write is forwarded so that a
  // start coinciding with a write streams the freshly written wave.
  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      step_vec[i] = '0;
      for (int w = 0; w < DIM; w++) begin
        if (int'(k) == w + i) begin
          if (wr_accept && int'(bus.wr_idx) == w) step_vec[i] = bus.wr_data[i];
          else                                    step_vec[i] = wave_mem[w][i];
        end
      end
    end
  end

  // Next-state and next-output logic; k counts steps already issued.
  always_comb begin
    state_next = state;
    k_next     = k;
    a_next     = a_reg;
    en_next    = 1'b0;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        busy_next = 1'b0;
        k_next    = '0;
        if (bus.start) begin
          state_next = STREAM;
          a_next     = step_vec;
          en_next    = 1'b1;
          busy_next  = 1'b1;
          k_next     = KW'(1);
        end
      end
      STREAM: begin
        busy_next = 1'b1;
        if (k == ALL_ISSUED) begin
          state_next = DONE;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          a_next     = '0;
        end else if (!bus.stall) begin
          a_next  = step_vec;
          en_next = 1'b1;
          k_next  = k + KW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        k_next     = '0;
        a_next     = '0;
      end
      default: begin
        state_next = IDLE;
        k_next     = '0;
        a_next     = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      a_reg    <= '0;
      en_reg   <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      state    <= state_next;
      k        <= k_next;
      a_reg    <= a_next;
      en_reg   <= en_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

  // Wave buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < DIM; w++) wave_mem[w] <= '0;
    end else if (wr_accept) begin
      wave_mem[bus.wr_idx] <= bus.wr_data;
    end
  end

  assign bus.A_out  = a_reg;
  assign bus.en_out = en_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: a wave-level reference model checked
// every cycle, plus literal expectations from hand-worked sequences.
module tb_systolic_skew_feeder;
  localparam int BITS_AB = 8;
  localparam int DIM     = 8;
  localparam int STEPS   = 2 * DIM - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.BITS_AB(BITS_AB), .DIM(DIM)) bus ();

  systolic_skew_feeder #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: buffer contents, and per stream the full diagonal
  // schedule computed up front from the buffer snapshot.
  int mdl_buf [DIM][DIM];
  int snap [STEPS][DIM];
  int exp_a [DIM];
  bit exp_en, exp_busy, exp_done;
  bit active, in_done, model_valid;
  int issued;

  // Model advance at every clock edge, from the inputs seen at that edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < DIM; w++)
        for (int i = 0; i < DIM; i++) mdl_buf[w][i] = 0;
      for (int i = 0; i < DIM; i++) exp_a[i] = 0;
      exp_en = 0; exp_busy = 0; exp_done = 0;
      active = 0; in_done = 0; issued = 0;
      model_valid = 1;
    end else if (in_done) begin
      in_done = 0;
      exp_done = 0; exp_busy = 0; exp_en = 0;
    end else if (active) begin
      if (issued == STEPS) begin
        active = 0; in_done = 1;
        exp_done = 1; exp_busy = 0; exp_en = 0;
        for (int i = 0; i < DIM; i++) exp_a[i] = 0;
      end else if (bus.stall) begin
        exp_en = 0;
      end else begin
        exp_a = snap[issued];
        issued++;
        exp_en = 1;
      end
    end else begin
      exp_en = 0; exp_done = 0; exp_busy = 0;
      if (bus.wr_en)
        for (int i = 0; i < DIM; i++) mdl_buf[bus.wr_idx][i] = $signed(bus.wr_data[i]);
      if (bus.start) begin
        for (int s = 0; s < STEPS; s++)
          for (int i = 0; i < DIM; i++)
            snap[s][i] = (s - i >= 0 && s - i < DIM) ? mdl_buf[s - i][i] : 0;
        active = 1; issued = 1;
        exp_a = snap[0];
        exp_en = 1; exp_busy = 1;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      tests_run++;
      for (int i = 0; i < DIM; i++) begin
        if ($signed(bus.A_out[i]) !== exp_a[i]) begin
          tests_failed++;
          $display("[TB] FAIL A_out lane %0d at %0t: got %0d expected %0d",
                   i, $time, $signed(bus.A_out[i]), exp_a[i]);
          break;
        end
      end
      tests_run++;
      if (bus.en_out !== exp_en) begin
        tests_failed++;
        $display("[TB] FAIL en_out at %0t: got %b expected %b", $time, bus.en_out, exp_en);
      end
      tests_run++;
      if (bus.busy !== exp_busy) begin
        tests_failed++;
        $display("[TB] FAIL busy at %0t: got %b expected %b", $time, bus.busy, exp_busy);
      end
      tests_run++;
      if (bus.done !== exp_done) begin
        tests_failed++;
        $display("[TB] FAIL done at %0t: got %b expected %b", $time, bus.done, exp_done);
      end
    end
  end

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, advance to the next negedge, then release.
  task automatic applyStimulus(input bit we, input int idx,
                               input logic [DIM-1:0][BITS_AB-1:0] data,
                               input bit st, input bit sl);
    bus.wr_en   = we;
    bus.wr_idx  = idx[$clog2(DIM)-1:0];
    bus.wr_data = data;
    bus.start   = st;
    bus.stall   = sl;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) @(negedge clk);
  endtask

  task automatic waitDone(input int budget, output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    tests_run++;
    if (bus.done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL done_timeout at %0t: got %b after %0d cycles expected 1",
               $time, bus.done, cycles);
    end
  endtask

  logic [DIM-1:0][BITS_AB-1:0] wave;
  logic [DIM-1:0][BITS_AB-1:0] zero_wave;
  int cyc, pulses;

  initial begin
    zero_wave   = '0;
    bus.wr_en   = 1'b0;
    bus.wr_idx  = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.stall   = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;

    // Reset state, then an immediate all-zero stream.
    checkOutput("reset_A_lo", bus.A_out[3:0], 0);
    checkOutput("reset_A_hi", bus.A_out[7:4], 0);
    checkOutput("reset_en", bus.en_out, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    applyStimulus(0, 0, zero_wave, 1, 0);
    checkOutput("zero_first_en", bus.en_out, 1);
    checkOutput("zero_first_A", bus.A_out[3:0], 0);
    waitDone(40, cyc);
    checkOutput("zero_done_cycle", cyc, 15);
    idle(1);

    // Basic skew with lane value 10*w+i.
    for (int w = 0; w < DIM; w++) begin
      for (int i = 0; i < DIM; i++) wave[i] = BITS_AB'(10 * w + i);
      applyStimulus(1, w, wave, 0, 0);
    end
    applyStimulus(0, 0, zero_wave, 1, 0);
    checkOutput("skew_t1_lane0", $signed(bus.A_out[0]), 0);
    checkOutput("skew_t1_en", bus.en_out, 1);
    idle(1);
    checkOutput("skew_t2_lane0", $signed(bus.A_out[0]), 10);
    checkOutput("skew_t2_lane1", $signed(bus.A_out[1]), 1);
    idle(6);
    checkOutput("skew_t8_lane7", $signed(bus.A_out[7]), 7);
    checkOutput("skew_t8_lane0", $signed(bus.A_out[0]), 70);
    idle(7);
    checkOutput("skew_t15_lane7", $signed(bus.A_out[7]), 77);
    checkOutput("skew_t15_lane0", $signed(bus.A_out[0]), 0);
    idle(1);
    checkOutput("skew_t16_done", bus.done, 1);
    idle(1);
    checkOutput("skew_t17_done", bus.done, 0);

    // Three stall cycles delay done by three.
    applyStimulus(0, 0, zero_wave, 1, 0);
    idle(2);
    for (int s = 0; s < 3; s++) applyStimulus(0, 0, zero_wave, 0, 1);
    checkOutput("stall_en", bus.en_out, 0);
    checkOutput("stall_lane0", $signed(bus.A_out[0]), 20);
    checkOutput("stall_lane2", $signed(bus.A_out[2]), 2);
    waitDone(40, cyc);
    checkOutput("stall_done_cycle", cyc, 13);
    idle(1);

    // Signed extremes.
    for (int i = 0; i < DIM; i++) wave[i] = 8'h80;
    applyStimulus(1, 0, wave, 0, 0);
    for (int i = 0; i < DIM; i++) wave[i] = 8'h7F;
    applyStimulus(1, 7, wave, 0, 0);
    applyStimulus(0, 0, zero_wave, 1, 0);
    checkOutput("ext_t1_lane0", $signed(bus.A_out[0]), -128);
    idle(7);
    checkOutput("ext_t8_lane0", $signed(bus.A_out[0]), 127);
    checkOutput("ext_t8_lane7", $signed(bus.A_out[7]), -128);
    waitDone(40, cyc);
    idle(1);

    // Writes and starts during a stream are ignored.
    applyStimulus(0, 0, zero_wave, 1, 0);
    idle(3);
    for (int i = 0; i < DIM; i++) wave[i] = 8'd55;
    applyStimulus(1, 5, wave, 0, 0);
    idle(1);
    checkOutput("ign_k5_lane0", $signed(bus.A_out[0]), 50);
    applyStimulus(0, 0, zero_wave, 1, 0);
    pulses = 0;
    for (int c = 0; c < 24; c++) begin
      if (bus.done === 1'b1) pulses++;
      @(negedge clk);
    end
    checkOutput("ign_done_pulses", pulses, 1);
    checkOutput("ign_idle_busy", bus.busy, 0);

    // Reset mid-stream.
    applyStimulus(0, 0, zero_wave, 1, 0);
    idle(6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_en", bus.en_out, 0);
    checkOutput("mid_rst_busy", bus.busy, 0);
    checkOutput("mid_rst_done", bus.done, 0);
    checkOutput("mid_rst_A_lo", bus.A_out[3:0], 0);
    checkOutput("mid_rst_A_hi", bus.A_out[7:4], 0);
    idle(3);
    applyStimulus(0, 0, zero_wave, 1, 0);
    idle(7);
    checkOutput("post_rst_lane0", $signed(bus.A_out[0]), 0);
    waitDone(40, cyc);
    idle(1);

    // Randomised traffic: writes, coincident write+start, stalls, stray inputs.
    for (int r = 0; r < 12; r++) begin
      for (int n = 0; n < int'($urandom_range(0, 4)); n++) begin
        for (int i = 0; i < DIM; i++) wave[i] = BITS_AB'($urandom);
        applyStimulus(1, int'($urandom_range(0, DIM - 1)), wave, 0, 0);
      end
      for (int i = 0; i < DIM; i++) wave[i] = BITS_AB'($urandom);
      applyStimulus($urandom_range(0, 1) == 1, int'($urandom_range(0, DIM - 1)), wave, 1, 0);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 80) begin
        for (int i = 0; i < DIM; i++) wave[i] = BITS_AB'($urandom);
        applyStimulus($urandom_range(0, 4) == 0, int'($urandom_range(0, DIM - 1)), wave,
                      $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
        cyc++;
      end
      checkOutput("rand_done_seen", bus.done, 1);
      idle(int'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
